// File: rtl/dna_port_pkg.sv
// dna_port_pkg: shared FSM encoding and width limits for the DNA port reader. Rev 1.0
`default_nettype none

package dna_port_pkg;

  localparam int DNA_WIDTH_MIN = 8;
  localparam int DNA_WIDTH_MAX = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } dna_state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dna_port_model.sv
// dna_port_model: behavioural serial DNA port (READ loads the ID, SHIFT clocks it out MSB first). Rev 1.0
`default_nettype none

module dna_port_model #(
  parameter int                   DNA_WIDTH     = 96,
  parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = {DNA_WIDTH{1'b0}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic read,
  input  logic shift,
  input  logic din,
  output logic dout
);

  logic [DNA_WIDTH-1:0] port_reg;

  // dout always presents the current MSB, so a shift exposes the bit below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_reg <= SIM_DNA_VALUE;
      dout     <= 1'b0;
    end else if (read) begin
      port_reg <= SIM_DNA_VALUE;
      dout     <= SIM_DNA_VALUE[DNA_WIDTH-1];
    end else if (shift) begin
      port_reg <= {port_reg[DNA_WIDTH-2:0], din};
      dout     <= port_reg[DNA_WIDTH-2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dna_port_reader.sv
// dna_port_reader: READ/SHIFT sequencer assembling the device ID from a serial DNA port. Rev 1.0
// Optional: DNA_PORT_READER_PARITY_EN adds dna_parity and a model consistency check.
`default_nettype none

module dna_port_reader
  import dna_port_pkg::*;
#(
  parameter int                   DNA_WIDTH     = 96,
  parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = {DNA_WIDTH{1'b0}},
  parameter int                   USE_MODEL     = 1,
  parameter int                   LOOPBACK      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 dna_valid,
  output logic [DNA_WIDTH-1:0] dna_value,
  output logic                 ext_read,
  output logic                 ext_shift,
  output logic                 ext_din,
  input  logic                 ext_dout
`ifdef DNA_PORT_READER_PARITY_EN
  ,
  output logic                 dna_parity
`endif
);

  localparam int            CW   = cnt_width(DNA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DNA_WIDTH - 1);

  dna_state_e           state, state_next;
  logic [CW-1:0]        bit_cnt;
  logic [DNA_WIDTH-1:0] sreg;
  logic                 port_read, port_shift, port_din, port_dout;

  if (DNA_WIDTH < DNA_WIDTH_MIN || DNA_WIDTH > DNA_WIDTH_MAX) begin : g_bad_width
    $error("dna_port_reader: DNA_WIDTH outside supported range");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    port_read  = 1'b0;
    port_shift = 1'b0;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD: begin
        port_read  = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        port_shift = 1'b1;
        if (bit_cnt == LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Loopback recirculates each bit into the port so a readout leaves it intact.
  assign port_din = (LOOPBACK != 0) ? (port_shift & port_dout) : 1'b0;

  // The result is registered on the last shift so done/dna_valid appear in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dna_valid <= 1'b0;
      dna_value <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            dna_valid <= 1'b0;
          end
        end
        LOAD: bit_cnt <= '0;
        SHIFT: begin
          sreg <= {sreg[DNA_WIDTH-2:0], port_dout};
          if (bit_cnt == LAST) begin
            dna_value <= {sreg[DNA_WIDTH-2:0], port_dout};
            dna_valid <= 1'b1;
            done      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

  generate
    if (USE_MODEL != 0) begin : g_model
      logic unused_ext_dout;
      assign unused_ext_dout = ext_dout;

      dna_port_model #(
        .DNA_WIDTH     (DNA_WIDTH),
        .SIM_DNA_VALUE (SIM_DNA_VALUE)
      ) u_model (
        .clk   (clk),
        .rst_n (rst_n),
        .read  (port_read),
        .shift (port_shift),
        .din   (port_din),
        .dout  (port_dout)
      );

      assign ext_read  = 1'b0;
      assign ext_shift = 1'b0;
      assign ext_din   = 1'b0;
    end else begin : g_ext
      assign ext_read  = port_read;
      assign ext_shift = port_shift;
      assign ext_din   = port_din;
      assign port_dout = ext_dout;
    end
  endgenerate

`ifdef DNA_PORT_READER_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc    <= 1'b0;
      dna_parity <= 1'b0;
    end else if (state == LOAD) begin
      par_acc <= 1'b0;
    end else if (state == SHIFT) begin
      par_acc <= par_acc ^ port_dout;
      if (bit_cnt == LAST) dna_parity <= par_acc ^ port_dout;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (state == DONE && USE_MODEL != 0 && dna_value != SIM_DNA_VALUE)
      $error("dna_port_reader: captured ID %0h differs from model value %0h", dna_value, SIM_DNA_VALUE);
  end
`endif
`endif

endmodule

`default_nettype wire
